// File: rtl/onehot_stream_pkg.sv
// Shared types and helpers for the one-hot to binary stream encoder.
package onehot_stream_pkg;

  typedef enum logic {
    ENC_OR,
    ENC_PRIO
  } enc_mode_e;

  function automatic int unsigned bin_width(int unsigned onehot_width);
    return (onehot_width <= 1) ? 1 : $clog2(onehot_width);
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros, MODE=1 leading zeros.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH <= 1) ? 1 : $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  // Scan from the far end so the last hit is the one nearest the counted edge.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (MODE ? in_i[WIDTH-1-i] : in_i[i]) begin
        cnt_o = CNT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_enc_lane.sv
// Combinational single-channel one-hot encoder producing index, zero and multi-hot flags.
module onehot_enc_lane
  import onehot_stream_pkg::*;
#(
  parameter int unsigned ONEHOT_WIDTH = 16,
  parameter enc_mode_e   MODE         = ENC_OR,
  parameter int unsigned BIN_WIDTH    = bin_width(ONEHOT_WIDTH)
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    bin_o,
  output logic                    zero_o,
  output logic                    multi_o
);

  if (ONEHOT_WIDTH == 1) begin : g_single
    assign bin_o   = '0;
    assign zero_o  = ~onehot_i[0];
    assign multi_o = 1'b0;
  end else begin : g_wide
    assign zero_o  = ~|onehot_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(onehot_i & (onehot_i - ONEHOT_WIDTH'(1)));

    if (MODE == ENC_PRIO) begin : g_prio
      lzc #(
        .WIDTH    (ONEHOT_WIDTH),
        .MODE     (1'b0),
        .CNT_WIDTH(BIN_WIDTH)
      ) u_lzc (
        .in_i (onehot_i),
        .cnt_o(bin_o)
      );
    end else begin : g_or
      always_comb begin
        bin_o = '0;
        for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
          if (onehot_i[i]) begin
            bin_o = bin_o | BIN_WIDTH'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/onehot_to_bin_stream.sv
// Registered multi-channel one-hot to binary encoder with valid/ready handshake
// and a saturating multi-hot error counter.
module onehot_to_bin_stream
  import onehot_stream_pkg::*;
#(
  parameter int unsigned ONEHOT_WIDTH  = 16,
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned PRIO_MODE     = 0,
  parameter int unsigned ERR_CNT_WIDTH = 8,
  parameter int unsigned BIN_WIDTH     = bin_width(ONEHOT_WIDTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NUM_CH*ONEHOT_WIDTH-1:0] onehot_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NUM_CH*BIN_WIDTH-1:0]    bin_o,
  output logic [NUM_CH-1:0]              zero_o,
  output logic [NUM_CH-1:0]              multi_o,
  output logic [ERR_CNT_WIDTH-1:0]       err_cnt_o,
  output logic                           err_sticky_o
);

  localparam enc_mode_e Mode = (PRIO_MODE != 0) ? ENC_PRIO : ENC_OR;

  logic [NUM_CH*BIN_WIDTH-1:0] bin_d, bin_q;
  logic [NUM_CH-1:0]           zero_d, zero_q;
  logic [NUM_CH-1:0]           multi_d, multi_q;
  logic                        valid_q;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_d, err_cnt_q;
  logic                        err_sticky_d, err_sticky_q;
  logic                        accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    onehot_enc_lane #(
      .ONEHOT_WIDTH(ONEHOT_WIDTH),
      .MODE        (Mode),
      .BIN_WIDTH   (BIN_WIDTH)
    ) u_lane (
      .onehot_i(onehot_i[c*ONEHOT_WIDTH +: ONEHOT_WIDTH]),
      .bin_o   (bin_d[c*BIN_WIDTH +: BIN_WIDTH]),
      .zero_o  (zero_d[c]),
      .multi_o (multi_d[c])
    );
  end

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  // Clear takes priority over a same-cycle erroneous accept.
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr_i) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (accept && |multi_d) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      bin_q        <= '0;
      zero_q       <= '0;
      multi_q      <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        bin_q   <= bin_d;
        zero_q  <= zero_d;
        multi_q <= multi_d;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign valid_o      = valid_q;
  assign bin_o        = bin_q;
  assign zero_o       = zero_q;
  assign multi_o      = multi_q;
  assign err_cnt_o    = err_cnt_q;
  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
// Bench for onehot_to_bin_stream: OR-mode, priority-mode (2-bit counter) and
// single-bit-width instances driven in lockstep and compared to a reference model.
module tb_onehot_to_bin_stream;

  logic clk = 1'b0;
  logic rst_n, clr, valid_in, ready_in;
  logic [31:0] oh;
  logic [2:0]  oh2;

  logic       rdy0, vld0, stk0, rdy1, vld1, stk1, rdy2, vld2, stk2;
  logic [7:0] bin0, bin1, cnt0, cnt2;
  logic [1:0] zero0, multi0, zero1, multi1, cnt1;
  logic [2:0] bin2, zero2, multi2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit         m_valid;
  logic [7:0] m_bin0, m_bin1;
  logic [1:0] m_zero, m_multi;
  logic [2:0] m_zero2;
  int         m_cnt0, m_cnt1;
  bit         m_stk;

  typedef struct {
    logic [31:0] oh;
    logic [7:0]  bin_or;
    logic [7:0]  bin_pri;
    logic [1:0]  zero;
    logic [1:0]  multi;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  onehot_to_bin_stream #(
    .ONEHOT_WIDTH(16), .NUM_CH(2), .PRIO_MODE(0), .ERR_CNT_WIDTH(8)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid_in), .ready_o(rdy0),
    .onehot_i(oh), .valid_o(vld0), .ready_i(ready_in), .bin_o(bin0), .zero_o(zero0),
    .multi_o(multi0), .err_cnt_o(cnt0), .err_sticky_o(stk0)
  );

  onehot_to_bin_stream #(
    .ONEHOT_WIDTH(16), .NUM_CH(2), .PRIO_MODE(1), .ERR_CNT_WIDTH(2)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid_in), .ready_o(rdy1),
    .onehot_i(oh), .valid_o(vld1), .ready_i(ready_in), .bin_o(bin1), .zero_o(zero1),
    .multi_o(multi1), .err_cnt_o(cnt1), .err_sticky_o(stk1)
  );

  onehot_to_bin_stream #(
    .ONEHOT_WIDTH(1), .NUM_CH(3), .PRIO_MODE(0), .ERR_CNT_WIDTH(8)
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid_in), .ready_o(rdy2),
    .onehot_i(oh2), .valid_o(vld2), .ready_i(ready_in), .bin_o(bin2), .zero_o(zero2),
    .multi_o(multi2), .err_cnt_o(cnt2), .err_sticky_o(stk2)
  );

  function automatic logic [3:0] ref_bin(logic [15:0] v, bit prio);
    logic [3:0] r = 4'd0;
    bit found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        if (!prio) r = r | 4'(i);
        else if (!found) begin
          r = 4'(i);
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_rdy = !m_valid || ready_in;
    chk("valid0", 64'(vld0), 64'(m_valid));
    chk("ready0", 64'(rdy0), 64'(exp_rdy));
    chk("bin0", 64'(bin0), 64'(m_bin0));
    chk("zero0", 64'(zero0), 64'(m_zero));
    chk("multi0", 64'(multi0), 64'(m_multi));
    chk("cnt0", 64'(cnt0), 64'(m_cnt0));
    chk("sticky0", 64'(stk0), 64'(m_stk));
    chk("valid1", 64'(vld1), 64'(m_valid));
    chk("ready1", 64'(rdy1), 64'(exp_rdy));
    chk("bin1", 64'(bin1), 64'(m_bin1));
    chk("zero1", 64'(zero1), 64'(m_zero));
    chk("multi1", 64'(multi1), 64'(m_multi));
    chk("cnt1", 64'(cnt1), 64'(m_cnt1));
    chk("sticky1", 64'(stk1), 64'(m_stk));
    chk("valid2", 64'(vld2), 64'(m_valid));
    chk("ready2", 64'(rdy2), 64'(exp_rdy));
    chk("bin2", 64'(bin2), 64'd0);
    chk("zero2", 64'(zero2), 64'(m_zero2));
    chk("multi2", 64'(multi2), 64'd0);
    chk("cnt2", 64'(cnt2), 64'd0);
    chk("sticky2", 64'(stk2), 64'd0);
  endtask

  task automatic update_model();
    bit acc = valid_in && (!m_valid || ready_in);
    logic [1:0] mh;
    mh[0] = $countones(oh[15:0]) > 1;
    mh[1] = $countones(oh[31:16]) > 1;
    if (!rst_n) begin
      m_valid = 0; m_bin0 = 0; m_bin1 = 0; m_zero = 0; m_multi = 0; m_zero2 = 0;
      m_cnt0 = 0; m_cnt1 = 0; m_stk = 0;
    end else begin
      if (acc) begin
        m_valid = 1;
        m_bin0  = {ref_bin(oh[31:16], 0), ref_bin(oh[15:0], 0)};
        m_bin1  = {ref_bin(oh[31:16], 1), ref_bin(oh[15:0], 1)};
        m_zero  = {oh[31:16] == 0, oh[15:0] == 0};
        m_multi = mh;
        m_zero2 = ~oh2;
      end else if (ready_in) begin
        m_valid = 0;
      end
      if (clr) begin
        m_cnt0 = 0; m_cnt1 = 0; m_stk = 0;
      end else if (acc && mh != 0) begin
        m_stk  = 1;
        m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
        m_cnt1 = (m_cnt1 < 3) ? m_cnt1 + 1 : 3;
      end
    end
  endtask

  // Check at the negative edge, advance the model at the positive edge.
  task automatic cycle();
    @(negedge clk);
    if (chk_en) check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  function automatic logic [15:0] rand_ch();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0: v = 16'(1) << $urandom_range(0, 15);
      1: v = 16'h0;
      2: v = 16'($urandom);
      default: v = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
    endcase
    return v;
  endfunction

  initial begin
    tbl[0] = '{32'h0100_0001, 8'h80, 8'h80, 2'b00, 2'b00};
    tbl[1] = '{32'h0000_0006, 8'h03, 8'h01, 2'b10, 2'b01};
    tbl[2] = '{32'h8000_0010, 8'hF4, 8'hF4, 2'b00, 2'b00};
    tbl[3] = '{32'hFFFF_0000, 8'hF0, 8'h00, 2'b01, 2'b10};
    tbl[4] = '{32'h0030_8001, 8'h5F, 8'h40, 2'b00, 2'b11};
    tbl[5] = '{32'h0000_0000, 8'h00, 8'h00, 2'b11, 2'b00};

    // Reset / idle
    rst_n = 0; clr = 0; valid_in = 0; ready_in = 1; oh = 0; oh2 = 0;
    cycle();
    chk_en = 1;
    cycle(); cycle();
    rst_n = 1;
    cycle();
    chk("rst_valid", 64'(vld0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_cnt", 64'(cnt0), 64'd0);

    // Directed table, one accepted beat per row
    foreach (tbl[i]) begin
      valid_in = 1; ready_in = 1; oh = tbl[i].oh; oh2 = tbl[i].oh[2:0];
      cycle();
      chk($sformatf("tbl%0d_valid", i), 64'(vld0), 64'd1);
      chk($sformatf("tbl%0d_bin_or", i), 64'(bin0), 64'(tbl[i].bin_or));
      chk($sformatf("tbl%0d_bin_pri", i), 64'(bin1), 64'(tbl[i].bin_pri));
      chk($sformatf("tbl%0d_zero", i), 64'(zero0), 64'(tbl[i].zero));
      chk($sformatf("tbl%0d_multi", i), 64'(multi0), 64'(tbl[i].multi));
    end
    valid_in = 0;
    cycle();

    // Backpressure: beat bin=1 held while stalled, then bin=2 follows
    ready_in = 0; valid_in = 1; oh = 32'h0002_0002;
    cycle();
    oh = 32'h0004_0004;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_hold_bin", 64'(bin0), 64'h11);
      chk("bp_hold_ready", 64'(rdy0), 64'd0);
    end
    ready_in = 1;
    cycle();
    chk("bp_second_bin", 64'(bin0), 64'h22);
    chk("bp_second_valid", 64'(vld0), 64'd1);
    valid_in = 0;
    cycle();
    chk("bp_drained", 64'(vld0), 64'd0);

    // Degenerate width instance
    valid_in = 1; oh2 = 3'b101; oh = 0;
    cycle();
    chk("w1_bin", 64'(bin2), 64'd0);
    chk("w1_zero", 64'(zero2), 64'b010);
    chk("w1_multi", 64'(multi2), 64'd0);

    // Saturation then clear-wins
    rst_n = 0; valid_in = 0;
    cycle();
    rst_n = 1; valid_in = 1; oh = 32'h0000_0003;
    for (int k = 0; k < 5; k++) cycle();
    chk("sat_cnt1", 64'(cnt1), 64'd3);
    chk("sat_cnt0", 64'(cnt0), 64'd5);
    clr = 1;
    cycle();
    clr = 0; valid_in = 0;
    chk("clr_cnt1", 64'(cnt1), 64'd0);
    chk("clr_sticky1", 64'(stk1), 64'd0);
    chk("clr_cnt0", 64'(cnt0), 64'd0);
    chk("clr_valid", 64'(vld0), 64'd1);
    cycle();

    // Randomised traffic including clears and mid-transfer resets
    for (int k = 0; k < 600; k++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      clr      = ($urandom_range(0, 15) == 0);
      valid_in = $urandom_range(0, 1);
      ready_in = ($urandom_range(0, 3) != 0);
      oh       = {rand_ch(), rand_ch()};
      oh2      = 3'($urandom);
      cycle();
    end
    rst_n = 1; clr = 0; valid_in = 0; ready_in = 1;
    cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_to_bin_stream.md
Name: onehot_to_bin_stream

Overview:
- Registered, multi-channel one-hot to binary encoder with valid/ready handshake.
- Each channel's binary index comes out one cycle after input acceptance.
- Flags empty (zero-hot) and multi-hot inputs; keeps a saturating error counter and a sticky error bit.
- Sits between arbiters/grant vectors and index-consuming datapaths where timing needs a register stage.

Parameters:
- ONEHOT_WIDTH, 16, bits per channel one-hot vector (>=1).
- NUM_CH, 1, number of independent channels encoded per beat (>=1).
- PRIO_MODE, 0, 0 = OR-encode (index = OR of indices of all set bits); 1 = lowest set bit wins.
- ERR_CNT_WIDTH, 8, width of saturating multi-hot error counter.
- BIN_WIDTH, ONEHOT_WIDTH==1 ? 1 : $clog2(ONEHOT_WIDTH), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- clr_i  in  1  synchronous clear of err_cnt_o and err_sticky_o.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- onehot_i  in  NUM_CH*ONEHOT_WIDTH  channel c at bits [c*ONEHOT_WIDTH +: ONEHOT_WIDTH].
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- bin_o  out  NUM_CH*BIN_WIDTH  channel c index at [c*BIN_WIDTH +: BIN_WIDTH].
- zero_o  out  NUM_CH  channel c input had no bit set.
- multi_o  out  NUM_CH  channel c input had more than one bit set.
- err_cnt_o  out  ERR_CNT_WIDTH  count of accepted beats with any multi_o bit set; saturating.
- err_sticky_o  out  1  set on first accepted multi-hot beat; held until clr_i or reset.

Behaviour:
- Reset (rst_ni==0 at posedge): valid_o=0, bin_o=0, zero_o=0, multi_o=0, err_cnt_o=0, err_sticky_o=0. Reset mid-transfer drops any held beat.
- Handshake: single pipeline register. ready_o = !valid_o || ready_i (combinational from ready_i and state). No combinational path from valid_i to valid_o.
- Accept (valid_i && ready_o): next cycle valid_o=1, and bin_o/zero_o/multi_o are loaded from the encoded input. Latency 1, throughput 1 beat/cycle.
- Drain (valid_o && ready_i && !(valid_i && ready_o)): valid_o goes to 0. Data fields hold their last value.
- Stall (valid_o && !ready_i): valid_o, bin_o, zero_o and multi_o stay stable. Input is not accepted.
- Encoding per channel:
  - PRIO_MODE=0: bin[j] = OR over set bits i of i[j]. Result is exact for one-hot input.
  - PRIO_MODE=1: bin = index of the lowest set bit.
  - Both modes: zero input gives bin=0 and zero=1.
  - multi = popcount>1, independent of mode.
- ONEHOT_WIDTH==1: bin always 0; zero = !onehot; multi always 0.
- Error counter:
  - Increments by exactly 1 per accepted beat with |multi (not per channel).
  - Saturates at all-ones.
  - Only accepted beats count; unaccepted valid_i never counts.
- clr_i:
  - Same-cycle clr_i and an erroneous accept: clear wins. Counter=0, sticky=0, and the event is not counted.
  - clr_i does not affect the datapath or valid_o.
- zero_o is informational only; it does not affect the counters.

Decomposition:
- Package onehot_stream_pkg: typedef enum logic {ENC_OR, ENC_PRIO} enc_mode_e, used for PRIO_MODE; localparam helper for BIN_WIDTH.
- Sub-module onehot_enc_lane: purely combinational single-channel encoder (bin, zero, multi), parametrised by ONEHOT_WIDTH and mode. Instantiated NUM_CH times in a generate loop.
- PRIO_MODE=1 uses the existing lzc cell (trailing-zero mode) inside onehot_enc_lane.
- Top level holds only the register stage, handshake and error counter.

Test Plan:
Config ONEHOT_WIDTH=16, NUM_CH=2 unless stated.
- Reset/idle: hold rst_ni=0 for 3 cycles, then release. Expect all outputs 0 and ready_o=1.
- Basic one-hot: onehot_i={16'h0100,16'h0001} accepted, ready_i=1. One cycle later expect valid_o=1, bin_o={4'd8,4'd0}, zero_o=0, multi_o=0, err_cnt_o=0.
- Backpressure: ready_i=0 for 4 cycles with valid_i=1 streaming 16'h0002, then 16'h0004. Expect first beat bin=1 held stable, ready_o=0 while stalled. After ready_i=1, beats delivered in order (bin 1, then 2) with no loss or duplication.
- Multi/zero, PRIO_MODE=0 vs 1: channel0=16'h0006, channel1=16'h0000.
  - PRIO_MODE=0: bin ch0=3, multi_o=2'b01, zero_o=2'b10.
  - PRIO_MODE=1: bin ch0=1.
  - Both modes: err_cnt_o=1, err_sticky_o=1.
- Saturation/clear, ERR_CNT_WIDTH=2: 5 consecutive accepted multi-hot beats give err_cnt_o=3 (saturated). Then clr_i together with a multi-hot accept gives err_cnt_o=0 and err_sticky_o=0 next cycle.
- Degenerate width, ONEHOT_WIDTH=1, NUM_CH=3: onehot_i=3'b101. Expect bin_o=3'b000, zero_o=3'b010, multi_o=0.
